// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard / stall sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam int WAIT_MAX_DEF = 15;
  localparam int CNT_W_DEF    = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: hold once all-ones is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV32 pipeline: load-use bubbles,
// redirect flushes, multi-cycle memory waits with timeout halt, perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_clr,
  output logic             idex_stall,
  output logic             idex_clr,
  output logic             exmem_stall,
  output logic             memwb_clr,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic              halted_q, halted_d;
  logic              lu;
  logic              mm;

  // Hazard detection: x0 is never a real producer.
  always_comb begin
    lu = idex_mem_read && (idex_rd != REG_ZERO) &&
         ((use_rs1 && (ifid_rs1 == idex_rd)) || (use_rs2 && (ifid_rs2 == idex_rd)));
    mm = mem_req && !mem_ready;
  end

  // Output priority mux: halt/miss freezes everything, then redirect, then load-use.
  // A frozen EX means redirect/load-use will re-present once the stall ends.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_clr    = 1'b0;
    idex_stall  = 1'b0;
    idex_clr    = 1'b0;
    exmem_stall = 1'b0;
    memwb_clr   = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if ((state_q == HALT) || mm) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_clr   = 1'b1;
    end else if (redirect) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (lu) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_clr   = 1'b1;
    end
  end

  // FSM next state: a miss in RUN opens a wait episode; MEM_WAIT exits on
  // completion (or a dropped request) and halts when the counter hits WAIT_MAX.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    case (state_q)
      RUN: begin
        if (mm) begin
          state_d = MEM_WAIT;
          wait_d  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mm) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WCNT_W'(WAIT_MAX)) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          wait_d = wait_q + WCNT_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // FSM state, wait counter and sticky halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      wait_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_stall),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ifid_clr),
    .q   (flush_cnt)
  );

endmodule
